// File: rtl/nixie_scanner.sv
// nixie_scanner
//   Time-multiplexed scan driver for a multi-digit seven-segment display.
//   A 32-bit value is written from the bus side into a shadow buffer (byte
//   merges). At each frame boundary a pending shadow is copied into the
//   displayed value, so a frame never mixes old and new digits. Digits are
//   stepped every SCAN_DIV cycles. Optional leading-zero blanking is applied.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en           : write strobe
//   wr_be[3:0]      : byte enables for wr_data
//   wr_data[31:0]   : value to display; nibble i -> digit i
//   blank_lz        : leading-zero suppression enable
//   digit_data[3:0] : nibble of the selected digit (0 when blanked)
//   digit_sel       : active-low one-hot digit enable (all ones when blanked)
//   frame_done      : one-cycle pulse when the scan wraps back to digit 0
module nixie_scanner #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_be,
  input  logic [31:0]       wr_data,
  input  logic              blank_lz,
  output logic [3:0]        digit_data,
  output logic [DIGITS-1:0] digit_sel,
  output logic              frame_done
);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]        IDX_LAST = 3'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_RST  = ~DIGITS'(1);

  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [31:0]      shadow, shadow_nx;
  logic [31:0]      disp, disp_nx;
  logic             pending, pending_nx;
  logic             tick, wrap;

  // nz[i]: some displayed nibble in i..DIGITS-1 is non-zero
  logic [7:0]        nz;
  logic              acc;
  logic              blank;
  logic [3:0]        data_nx;
  logic [DIGITS-1:0] sel_nx;

  always_comb begin
    tick       = (cnt == DIV_LAST);
    wrap       = tick && (idx == IDX_LAST);
    cnt_nx     = tick ? '0 : cnt + 1'b1;
    idx_nx     = wrap ? 3'd0 : (tick ? idx + 3'd1 : idx);
    // The boundary loads the shadow as it stood before this edge; a write on
    // the same edge re-arms pending and is shown one frame later.
    disp_nx    = (wrap && pending) ? shadow : disp;
    pending_nx = wrap ? wr_en : (pending | wr_en);
    shadow_nx  = shadow;
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) shadow_nx[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  // Outputs are registered from next-state values so they change on the
  // same edge that moves idx or swaps in a new frame.
  always_comb begin
    acc = 1'b0;
    nz  = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < DIGITS) acc = acc | (|disp_nx[4*i +: 4]);
      nz[i] = acc;
    end
    blank   = blank_lz && (idx_nx != 3'd0) && !nz[idx_nx];
    data_nx = blank ? 4'd0 : disp_nx[4*idx_nx +: 4];
    sel_nx  = blank ? '1 : ~(DIGITS'(1) << idx_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 3'd0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      digit_data <= 4'd0;
      digit_sel  <= SEL_RST;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      shadow     <= shadow_nx;
      disp       <= disp_nx;
      pending    <= pending_nx;
      digit_data <= data_nx;
      digit_sel  <= sel_nx;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_nixie_scanner.sv
// Self-checking bench for nixie_scanner. Three instances share the inputs:
//   A: 8 digits, 4 cycles/digit   B: 8 digits, 1 cycle/digit
//   C: 5 digits, 3 cycles/digit
// The stimulus process pushes the expected outputs after every edge into a
// queue; a monitor pops and compares on the falling edge.
module tb_nixie_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, blank_lz;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  logic [3:0] dd_a, dd_b, dd_c;
  logic [7:0] ds_a, ds_b;
  logic [4:0] ds_c;
  logic       fd_a, fd_b, fd_c;

  nixie_scanner #(.DIGITS(8), .SCAN_DIV(4), .DIV_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data),
    .blank_lz(blank_lz), .digit_data(dd_a), .digit_sel(ds_a), .frame_done(fd_a));
  nixie_scanner #(.DIGITS(8), .SCAN_DIV(1), .DIV_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data),
    .blank_lz(blank_lz), .digit_data(dd_b), .digit_sel(ds_b), .frame_done(fd_b));
  nixie_scanner #(.DIGITS(5), .SCAN_DIV(3), .DIV_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data),
    .blank_lz(blank_lz), .digit_data(dd_c), .digit_sel(ds_c), .frame_done(fd_c));

  typedef struct packed {
    logic [2:0][7:0] sel;
    logic [2:0][3:0] data;
    logic [2:0]      fd;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  int dig[3] = '{8, 8, 5};
  int sdv[3] = '{4, 1, 3};

  // Reference model: edges since reset release, the bus-side merged value,
  // the value shown in the current frame, and whether a newer value waits.
  int          k[3];
  logic [31:0] m_shadow[3];
  logic [31:0] m_disp[3];
  bit          m_pend[3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      k[i] = 0; m_shadow[i] = '0; m_disp[i] = '0; m_pend[i] = 1'b0;
    end
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.sel[0] = 8'hFE; e.sel[1] = 8'hFE; e.sel[2] = 8'h1E;
    e.data = '0; e.fd = '0;
    return e;
  endfunction

  // Apply one rising edge with the current inputs and return the outputs
  // the display should show afterwards.
  function automatic exp_t model_edge();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      int          frame;
      int          pos;
      bit          bnd;
      logic [31:0] merged;
      logic [31:0] vis;
      logic [7:0]  mask;
      frame = dig[i] * sdv[i];
      k[i]++;
      bnd = (k[i] % frame) == 0;
      merged = m_shadow[i];
      if (wr_en)
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
      if (bnd) begin
        if (m_pend[i]) m_disp[i] = m_shadow[i];
        m_pend[i] = wr_en;
      end else begin
        m_pend[i] = m_pend[i] | wr_en;
      end
      m_shadow[i] = merged;
      pos  = (k[i] / sdv[i]) % dig[i];
      mask = 8'((32'd1 << dig[i]) - 1);
      vis  = (dig[i] == 8) ? m_disp[i] : (m_disp[i] & ((32'd1 << (4 * dig[i])) - 1));
      if (blank_lz && pos != 0 && (vis >> (4 * pos)) == 0) begin
        e.sel[i]  = mask;
        e.data[i] = 4'd0;
      end else begin
        e.sel[i]  = ~(8'd1 << pos) & mask;
        e.data[i] = 4'((vis >> (4 * pos)) & 32'hF);
      end
      e.fd[i] = bnd;
    end
    return e;
  endfunction

  function automatic void check(input int i, input logic [7:0] s, input logic [3:0] d,
                                input logic f, input exp_t e);
    n_total++;
    if (s === e.sel[i] && d === e.data[i] && f === e.fd[i]) n_pass++;
    else $display("FAIL inst%0d cyc%0d: got sel=%h data=%h fd=%b, expected sel=%h data=%h fd=%b",
                  i, cyc, s, d, f, e.sel[i], e.data[i], e.fd[i]);
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(0, ds_a, dd_a, fd_a, e);
        check(1, ds_b, dd_b, fd_b, e);
        check(2, {3'b000, ds_c}, dd_c, fd_c, e);
      end
    end
  end

  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst_n) e = model_edge();
    else begin model_reset(); e = rst_exp(); end
    q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  // Assert reset just after an edge; outputs must return to defaults
  // before the next falling edge.
  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    e = rst_exp();
    q.push_back(e);
    #1;
    rst_n = 1'b0;
    model_reset();
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_be = '0; wr_data = '0; blank_lz = 1'b0;
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(10);

    // full-frame scan
    wr(32'h8765_4321, 4'hF);
    run(80);

    // double buffering: write during digit 3 of a frame showing 0
    wr(32'h0, 4'hF);
    run(70);
    while ((((k[0] + 1) / 4) % 8) != 3) step();
    wr(32'hAAAA_AAAA, 4'hF);
    run(70);

    // byte enable on the boundary edge
    wr(32'h1234_5678, 4'hF);
    run(70);
    while (((k[0] + 1) % 32) != 0) step();
    wr(32'hFFFF_FFFF, 4'b0010);
    run(70);

    // leading-zero suppression
    blank_lz = 1'b1;
    wr(32'h0000_0A05, 4'hF);
    run(70);
    wr(32'h0, 4'hF);
    run(70);
    blank_lz = 1'b0;
    run(10);

    // reset mid-scan
    wr(32'h0000_3333, 4'h3);
    run(13);
    do_reset();
    run(40);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_be   = 4'($urandom);
      wr_data = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end
    wr_en = 1'b0;
    run(5);

    @(negedge clk);
    #1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
